dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving the pipelined CPU's MEM-stage load/store requests over a valid/ready handshake. It holds a word-addressed memory array, inserts a programmable number of wait states and returns read data, or an error flag, with a one-cycle response pulse. It also drives a stall line that freezes the pipeline while a request is outstanding. It replaces the zero-latency combinational data memory, so the pipeline can be exercised against realistic memory latency.

## Interface
- ADDR_WIDTH, 10, word-address bits; capacity 2^ADDR_WIDTH 32-bit words (4 KiB at default)
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15
- clock  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-high; clears all state except the memory array
- req_valid  in  1  request present; held high by the CPU while stall is high
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit i writes bits [8i+7:8i]
- req_ready  out  1  responder can accept a request this cycle
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access; valid with resp_valid
- stall  out  1  pipeline hold request to the hazard logic

## Operation
- Three states: IDLE, BUSY and RESP. Reset state is IDLE.
- IDLE
  - req_ready = 1.
  - On req_valid & req_ready, latch write, addr, wdata and be.
  - Go to BUSY with wait counter = WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES = 0.
- BUSY
  - req_ready = 0.
  - The counter decrements each cycle. When it is 0, perform the access and go to RESP.
- RESP
  - req_ready = 0 and resp_valid = 1 for exactly one cycle.
  - Unconditionally return to IDLE. A request is never accepted in RESP.
- Address decode
  - Word index = addr[ADDR_WIDTH+1:2].
  - Error if addr[1:0] != 0 or addr[31:ADDR_WIDTH+2] != 0.
- Access, performed on the edge entering RESP
  - Load: the array word is registered into resp_rdata.
  - Store: each byte with be[i] = 1 is written; resp_rdata = 0.
  - Store with be = 0: no change, no error.
  - Error: array untouched, resp_rdata = 0, resp_err = 1.
- stall
  - Combinational: (state == IDLE & req_valid) | (state == BUSY).
  - Low during RESP, so the MEM stage advances in the same cycle resp_rdata is valid.
- req_valid dropping during BUSY is ignored; the latched request still completes and responds.
- Input changes after acceptance have no effect; only the latched copy is used.
- Memory array is not cleared by reset. Simulation initial contents are all zero.

## Timing
- Reset values: req_ready = 1 once reset deasserts, and 0 while reset is high. resp_valid, resp_rdata, resp_err and stall are all 0.
- Reset mid-operation (BUSY or RESP) aborts the request immediately:
  - no response is produced;
  - a pending store is discarded, and the array is unmodified if reset arrives before the RESP edge.
- Latency: request accepted at edge k; resp_valid is high in the cycle following edge k+WAIT_CYCLES.
- stall is high for WAIT_CYCLES+1 cycles per request: the accept cycle plus the BUSY cycles.
- resp_rdata and resp_err are registered and are 0 in every cycle where resp_valid = 0.
- Maximum throughput is one request per WAIT_CYCLES+2 cycles. The next request can be accepted in the IDLE cycle right after RESP.
- A load after a store to the same word returns the stored data; the store completes before the load is accepted.

## Test plan
- **Reset during a store:** WAIT_CYCLES = 2; store 0x0000_0010 data 0xCAFEF00D; assert reset in the first BUSY cycle.
  - Required: all outputs 0, no resp_valid.
  - A subsequent load of 0x10 returns 0x0000_0000.
- **Store then load:** WAIT_CYCLES = 2; store 0x40 data 0xDEADBEEF, be 1111; then load 0x40.
  - Required: each request shows stall high for 3 cycles, then resp_valid for 1 cycle.
  - Load returns resp_rdata = 0xDEADBEEF, resp_err = 0.
- **Byte enables:** store 0x40 data 0x11223344, be 0101 over 0xDEADBEEF.
  - Required: a load of 0x40 returns 0xDE22BE44.
- **Error cases:** load 0x42 (misaligned), then store 0x1000 (out of range, ADDR_WIDTH = 10).
  - Required: each gives resp_valid with resp_err = 1 and resp_rdata = 0.
  - A load of 0xFFC (last valid word) still returns its prior contents and resp_err = 0.
- **Zero wait states, back-to-back:** WAIT_CYCLES = 0; req_valid held high for 4 loads.
  - Required: stall is high 1 cycle per request, resp_valid in the following cycle, and a new acceptance every 2 cycles.
- **req_valid dropped in BUSY:** WAIT_CYCLES = 3; load 0x40 accepted, then req_valid deasserted during BUSY.
  - Required: resp_valid still occurs 4 cycles after the accept edge with 0xDE22BE44.
  - req_ready returns to 1 the cycle after RESP.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word-addressed array behind a valid/ready
// handshake, with programmable wait states, one-cycle response pulse and a pipeline stall.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  accept;
  logic                  do_access;
  logic                  mem_we;
  logic                  cur_write;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [3:0]            cur_be;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign stall     = !reset && (((state_q == IDLE) && req_valid) || (state_q == BUSY));

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  assign addr_err  = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign word_idx  = cur_addr[ADDR_WIDTH+1:2];
  assign do_access = (accept && ZERO_WAIT) || ((state_q == BUSY) && (cnt_q == 4'd0));
  assign mem_we    = do_access && cur_write && !addr_err && !reset;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_INIT;
          state_d = ZERO_WAIT ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      resp_valid_d = 1'b1;
      resp_err_d   = addr_err;
      if (!addr_err && !cur_write) begin
        resp_rdata_d = mem[word_idx];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The array has no reset so its contents survive a pipeline reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) begin
          mem[word_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 3 wait states) driven with directed
// and random requests, checked against a per-instance array model and a request timeline.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic        rv    [3];
  logic        rw    [3];
  logic [31:0] ra    [3];
  logic [31:0] rwd   [3];
  logic [3:0]  rbe   [3];
  logic        ready [3];
  logic        vld   [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        stl   [3];

  int wc [3] = '{2, 0, 3};
  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [3][1024];

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut0 (
    .clock(clock), .reset(reset), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_be(rbe[0]), .req_ready(ready[0]), .resp_valid(vld[0]),
    .resp_rdata(rdata[0]), .resp_err(err[0]), .stall(stl[0]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_be(rbe[1]), .req_ready(ready[1]), .resp_valid(vld[1]),
    .resp_rdata(rdata[1]), .resp_err(err[1]), .stall(stl[1]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut2 (
    .clock(clock), .reset(reset), .req_valid(rv[2]), .req_write(rw[2]), .req_addr(ra[2]),
    .req_wdata(rwd[2]), .req_be(rbe[2]), .req_ready(ready[2]), .resp_valid(vld[2]),
    .resp_rdata(rdata[2]), .resp_err(err[2]), .stall(stl[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a 4 KiB word array, anything unaligned or at/after byte 4096 is an error.
  task automatic modelAccess(input int i, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    exp_err = (addr % 4 != 0) || (addr >= 32'd4096);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      idx = int'(addr / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[i][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = mdl[i][idx];
      end
    end
  endtask

  // Entered and left at posedge+1 with instance i idle; walks the accept/wait/response timeline.
  task automatic applyStimulus(input int i, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit drop, input bit hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    modelAccess(i, wr, addr, wdata, be, exp_rd, exp_err);
    rv[i] = 1'b1; rw[i] = wr; ra[i] = addr; rwd[i] = wdata; rbe[i] = be;
    @(negedge clock);
    checkOutput($sformatf("i%0d accept ready", i), 32'(ready[i]), 32'd1);
    checkOutput($sformatf("i%0d accept stall", i), 32'(stl[i]), 32'd1);
    checkOutput($sformatf("i%0d accept resp_valid", i), 32'(vld[i]), 32'd0);
    @(posedge clock); #1;
    for (int c = 1; c <= wc[i]; c++) begin
      rv[i] = drop ? 1'b0 : 1'b1;
      rw[i] = 1'($urandom); ra[i] = $urandom; rwd[i] = $urandom; rbe[i] = 4'($urandom);
      @(negedge clock);
      checkOutput($sformatf("i%0d wait%0d ready", i, c), 32'(ready[i]), 32'd0);
      checkOutput($sformatf("i%0d wait%0d stall", i, c), 32'(stl[i]), 32'd1);
      checkOutput($sformatf("i%0d wait%0d resp_valid", i, c), 32'(vld[i]), 32'd0);
      checkOutput($sformatf("i%0d wait%0d rdata", i, c), rdata[i], 32'd0);
      checkOutput($sformatf("i%0d wait%0d err", i, c), 32'(err[i]), 32'd0);
      @(posedge clock); #1;
    end
    rv[i] = hold;
    rw[i] = 1'($urandom); ra[i] = $urandom; rwd[i] = $urandom; rbe[i] = 4'($urandom);
    @(negedge clock);
    checkOutput($sformatf("i%0d resp resp_valid", i), 32'(vld[i]), 32'd1);
    checkOutput($sformatf("i%0d resp rdata a=%h", i, addr), rdata[i], exp_rd);
    checkOutput($sformatf("i%0d resp err a=%h", i, addr), 32'(err[i]), 32'(exp_err));
    checkOutput($sformatf("i%0d resp stall", i), 32'(stl[i]), 32'd0);
    checkOutput($sformatf("i%0d resp ready", i), 32'(ready[i]), 32'd0);
    @(posedge clock); #1;
    if (!hold) rv[i] = 1'b0;
  endtask

  task automatic checkIdle(input int i);
    @(negedge clock);
    checkOutput($sformatf("i%0d idle ready", i), 32'(ready[i]), 32'd1);
    checkOutput($sformatf("i%0d idle stall", i), 32'(stl[i]), 32'd0);
    checkOutput($sformatf("i%0d idle resp_valid", i), 32'(vld[i]), 32'd0);
    checkOutput($sformatf("i%0d idle rdata", i), rdata[i], 32'd0);
    checkOutput($sformatf("i%0d idle err", i), 32'(err[i]), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic checkResetOutputs(input int i, input logic exp_ready);
    checkOutput($sformatf("i%0d rst ready", i), 32'(ready[i]), 32'(exp_ready));
    checkOutput($sformatf("i%0d rst resp_valid", i), 32'(vld[i]), 32'd0);
    checkOutput($sformatf("i%0d rst rdata", i), rdata[i], 32'd0);
    checkOutput($sformatf("i%0d rst err", i), 32'(err[i]), 32'd0);
    checkOutput($sformatf("i%0d rst stall", i), 32'(stl[i]), 32'd0);
  endtask

  initial begin
    logic        wr;
    logic [31:0] addr;
    int          r;

    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 1024; w++) mdl[i][w] = 32'd0;
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 32'd0; rwd[i] = 32'd0; rbe[i] = 4'd0;
    end
    reset = 1'b1;

    @(negedge clock);
    for (int i = 0; i < 3; i++) checkResetOutputs(i, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) checkIdle(i);

    $display("[TB] reset during a pending store");
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h10; rwd[0] = 32'hCAFEF00D; rbe[0] = 4'hF;
    @(negedge clock);
    checkOutput("i0 abort accept stall", 32'(stl[0]), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1; rv[0] = 1'b0;
    #1;
    checkResetOutputs(0, 1'b0);
    @(negedge clock);
    checkResetOutputs(0, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      checkResetOutputs(0, 1'b1);
    end
    @(posedge clock); #1;
    applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 1'b0);

    $display("[TB] store, load, byte enables, errors");
    applyStimulus(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, 1'b0);
    checkOutput("i0 byte enable model", mdl[0][16], 32'hDE22BE44);
    applyStimulus(0, 1'b1, 32'h44, 32'h55667788, 4'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h44, 32'd0, 4'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h42, 32'd0, 4'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'hFFC, 32'd0, 4'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'd0, 4'h0, 1'b0, 1'b0);
    checkIdle(0);

    $display("[TB] zero wait states, back to back");
    applyStimulus(1, 1'b1, 32'h40, 32'hA5A5_0001, 4'hF, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 32'h44, 32'hA5A5_0002, 4'hF, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h44, 32'd0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h48, 32'd0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h42, 32'd0, 4'h0, 1'b0, 1'b0);
    checkIdle(1);

    $display("[TB] req_valid dropped while waiting");
    applyStimulus(2, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 32'h40, 32'h11223344, 4'b0101, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 32'h40, 32'd0, 4'h0, 1'b1, 1'b0);
    checkOutput("i2 byte enable model", mdl[2][16], 32'hDE22BE44);
    checkIdle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 30; n++) begin
        wr   = 1'($urandom);
        addr = 32'h100 + 4 * ($urandom % 8);
        r    = int'($urandom % 10);
        if (r == 0) addr = addr + 32'($urandom_range(1, 3));
        else if (r == 1) addr = 32'h1000 + 4 * ($urandom % 4);
        else if (r == 2) addr = 32'hFFFF_FFFC;
        applyStimulus(i, wr, addr, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
      end
      rv[i] = 1'b0;
      checkIdle(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
